pipe_stage_buf: RTL and testbench

Parametrised elastic pipeline stage register: the generalised successor of the fixed-field stage registers between IF/ID/EX/MEM/WB. Each field set previously hand-packed per stage is replaced by two configurable payload buses: data and control. The old 2-bit stall/clear select is replaced by a valid/ready handshake plus a synchronous flush. An optional 2-entry skid mode breaks the combinational ready path. A saturating stall counter supports hazard-unit performance tuning.

---
 rtl/pipe_stage_buf_if.sv | 34 +++
 rtl/pipe_stage_buf.sv | 137 +++++++++++++
 tb/tb_pipe_stage_buf.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_buf_if.sv
// Handshake and payload bundle around one pipe_stage_buf: upstream valid/ready/payload,
// downstream valid/ready/payload, flush and the stall counter readback.
`default_nettype none

interface pipe_stage_buf_if #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 13,
  parameter int CNT_W  = 16
);
  logic              i_flush;
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_data;
  logic [CTRL_W-1:0] i_ctrl;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;
  logic [CTRL_W-1:0] o_ctrl;
  logic [CNT_W-1:0]  o_stall_cnt;

  // Producer/consumer side: drives the stage inputs and observes its outputs.
  modport master (
    output i_flush, i_valid, i_data, i_ctrl, i_ready,
    input  o_ready, o_valid, o_data, o_ctrl, o_stall_cnt
  );

  // The stage itself.
  modport slave (
    input  i_flush, i_valid, i_data, i_ctrl, i_ready,
    output o_ready, o_valid, o_data, o_ctrl, o_stall_cnt
  );
endinterface

`default_nettype wire

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic pipeline stage register with flush and saturating stall counter.
// Define PIPE_STAGE_SKID_EN for the 2-entry skid buffer with registered o_ready.
`default_nettype none

module pipe_stage_buf #(
  parameter int DATA_W         = 96,
  parameter int CTRL_W         = 13,
  parameter bit CLEAR_ON_FLUSH = 1'b1,
  parameter int CNT_W          = 16
) (
  input  wire logic       i_clk,
  input  wire logic       i_rst_n,
  pipe_stage_buf_if.slave bus
);

  localparam int PW = DATA_W + CTRL_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    main_q, main_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic          w_valid;
  logic          w_ready;
  logic          w_accept;
  logic          w_drain;
  logic [PW-1:0] w_in;

  assign w_in    = {bus.i_data, bus.i_ctrl};
  assign w_valid = (state_q != ST_EMPTY);

`ifdef PIPE_STAGE_SKID_EN
  logic [PW-1:0] skid_q, skid_d;
  logic          ready_q;

  // Ready depends only on a flop, so downstream back-pressure never ripples upstream in one cycle.
  assign w_ready = ready_q;
`else
  assign w_ready = !w_valid || bus.i_ready;
`endif

  assign w_accept = bus.i_valid && w_ready;
  assign w_drain  = w_valid && bus.i_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_d  = skid_q;
`endif
    if (bus.i_flush) begin
      // A drain in this cycle still completes downstream; anything accepted is dropped.
      state_d = ST_EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_d = '0;
`ifdef PIPE_STAGE_SKID_EN
        skid_d = '0;
`endif
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (w_accept) begin
            main_d  = w_in;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_drain) begin
            main_d = w_in;
`ifdef PIPE_STAGE_SKID_EN
          end else if (w_accept) begin
            skid_d  = w_in;
            state_d = ST_FULL;
`endif
          end else if (w_drain) begin
            state_d = ST_EMPTY;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        ST_FULL: begin
          if (w_drain) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
`endif
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (w_valid && !bus.i_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      skid_q  <= skid_d;
      ready_q <= (state_d != ST_FULL);
    end
  end
`endif

  assign bus.o_valid     = w_valid;
  assign bus.o_ready     = w_ready;
  assign bus.o_data      = main_q[PW-1:CTRL_W];
  assign bus.o_ctrl      = main_q[CTRL_W-1:0];
  assign bus.o_stall_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf against a queue-based reference of the stage.
// Covers both builds (PIPE_STAGE_SKID_EN defined or not).
`default_nettype none

module tb_pipe_stage_buf;

  localparam int     DATA_W  = 96;
  localparam int     CTRL_W  = 13;
  localparam int     CNT_W   = 16;
  localparam int     PW      = DATA_W + CTRL_W;
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
  localparam int CAP  = 2;
`else
  localparam bit SKID = 1'b0;
  localparam int CAP  = 1;
`endif

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;

  pipe_stage_buf_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

  pipe_stage_buf #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLEAR_ON_FLUSH(1'b1), .CNT_W(CNT_W)
  ) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  always #5 i_clk = ~i_clk;

  // Reference: an ordered list of held payloads, bounded by the stage capacity.
  logic [PW-1:0] mq[$];
  longint        m_cnt  = 0;
  bit            m_zero = 1'b1;
  int            n_checks = 0;
  int            n_pass   = 0;

  function automatic bit m_ready();
    return (mq.size() < CAP) || (!SKID && bus.i_ready);
  endfunction

  // Advance the reference by one clock using the inputs as they stand, then move to the next negedge.
  task automatic tick();
    bit rdy, drn, acc;
    if (!i_rst_n) begin
      mq.delete();
      m_cnt  = 0;
      m_zero = 1'b1;
    end else begin
      rdy = m_ready();
      drn = (mq.size() > 0) && bus.i_ready;
      acc = bus.i_valid && rdy;
      if ((mq.size() > 0) && !bus.i_ready && (m_cnt < CNT_MAX)) m_cnt++;
      if (bus.i_flush) begin
        mq.delete();
        m_zero = 1'b1;
      end else begin
        if (drn) void'(mq.pop_front());
        if (acc) begin
          mq.push_back({bus.i_data, bus.i_ctrl});
          m_zero = 1'b0;
        end
      end
    end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic drive(input bit v, input logic [DATA_W-1:0] d, input bit r, input bit f);
    bus.i_valid = v;
    bus.i_data  = d;
    bus.i_ctrl  = CTRL_W'(d);
    bus.i_ready = r;
    bus.i_flush = f;
  endtask

  task automatic test_reset();
    drive(1'b1, 96'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF, 1'b1, 1'b0);
    repeat (3) tick();
    #1;
    n_checks++;
    if (bus.o_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.o_valid);
    else n_pass++;
    n_checks++;
    if (bus.o_data !== '0) $display("FAIL reset_data: got %h expected 0", bus.o_data);
    else n_pass++;
    n_checks++;
    if (bus.o_ctrl !== '0) $display("FAIL reset_ctrl: got %h expected 0", bus.o_ctrl);
    else n_pass++;
    n_checks++;
    if (bus.o_stall_cnt !== '0) $display("FAIL reset_cnt: got %0d expected 0", bus.o_stall_cnt);
    else n_pass++;
    n_checks++;
    if (bus.o_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", bus.o_ready);
    else n_pass++;
    i_rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.o_valid !== 1'b0) $display("FAIL release_no_early_accept: got %b expected 0", bus.o_valid);
    else n_pass++;
    tick();
    #1;
    n_checks++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 96'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF)
      $display("FAIL first_accept: got v=%b d=%h expected v=1 d=deadbeef..", bus.o_valid, bus.o_data);
    else n_pass++;
  endtask

  task automatic test_stream();
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, DATA_W'(k), 1'b1, 1'b0);
      #1;
      n_checks++;
      if (bus.o_ready !== 1'b1) $display("FAIL stream_ready[%0d]: got %b expected 1", k, bus.o_ready);
      else n_pass++;
      if (k > 1) begin
        n_checks++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== DATA_W'(k - 1) || bus.o_ctrl !== CTRL_W'(k - 1))
          $display("FAIL stream_out[%0d]: got v=%b d=%h expected d=%h", k, bus.o_valid, bus.o_data, k - 1);
        else n_pass++;
      end
      tick();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== DATA_W'(8))
      $display("FAIL stream_last: got v=%b d=%h expected d=8", bus.o_valid, bus.o_data);
    else n_pass++;
    tick();
    #1;
    n_checks++;
    if (bus.o_valid !== 1'b0) $display("FAIL stream_empty: got %b expected 0", bus.o_valid);
    else n_pass++;
  endtask

`ifdef PIPE_STAGE_SKID_EN
  task automatic test_skid();
    logic [DATA_W-1:0] got[$];
    bit acc;
    drive(1'b1, 96'h10, 1'b1, 1'b0);
    tick();
    drive(1'b1, 96'h11, 1'b0, 1'b0);
    tick();
    drive(1'b1, 96'h12, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 96'h10 || bus.o_ready !== 1'b0)
      $display("FAIL skid_full: got v=%b d=%h rdy=%b expected v=1 d=10 rdy=0",
               bus.o_valid, bus.o_data, bus.o_ready);
    else n_pass++;
    tick();
    bus.i_ready = 1'b1;
    for (int n = 0; n < 10 && got.size() < 3; n++) begin
      #1;
      if (bus.o_valid) got.push_back(bus.o_data);
      acc = bus.i_valid && bus.o_ready;
      tick();
      if (acc) bus.i_valid = 1'b0;
    end
    n_checks++;
    if (got.size() != 3) $display("FAIL skid_count: got %0d expected 3", got.size());
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= got.size() || got[i] !== DATA_W'(16 + i))
        $display("FAIL skid_order[%0d]: got %h expected %h", i, (i < got.size()) ? got[i] : 'x, 16 + i);
      else n_pass++;
    end
  endtask
`else
  task automatic test_single_replace();
    drive(1'b1, 96'h20, 1'b0, 1'b0);
    tick();
    drive(1'b1, 96'h21, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (bus.o_ready !== 1'b0) $display("FAIL single_blocked: got %b expected 0", bus.o_ready);
    else n_pass++;
    bus.i_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.o_ready !== 1'b1) $display("FAIL single_comb_ready: got %b expected 1", bus.o_ready);
    else n_pass++;
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 96'h21)
      $display("FAIL single_replace: got v=%b d=%h expected v=1 d=21", bus.o_valid, bus.o_data);
    else n_pass++;
    bus.i_ready = 1'b1;
    tick();
  endtask
`endif

  task automatic test_flush();
    for (int n = 0; n < 4 && mq.size() < CAP; n++) begin
      drive(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 96'h55, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (bus.o_valid !== 1'b1 || bus.o_ready !== 1'b0)
      $display("FAIL flush_prefull: got v=%b rdy=%b expected v=1 rdy=0", bus.o_valid, bus.o_ready);
    else n_pass++;
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (bus.o_valid !== 1'b0 || bus.o_data !== '0 || bus.o_ctrl !== '0)
      $display("FAIL flush_clear: got v=%b d=%h c=%h expected 0/0/0", bus.o_valid, bus.o_data, bus.o_ctrl);
    else n_pass++;
    bus.i_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      #1;
      n_checks++;
      if (bus.o_valid !== 1'b0) $display("FAIL flush_no_55[%0d]: got v=%b d=%h expected v=0", n, bus.o_valid, bus.o_data);
      else n_pass++;
      tick();
    end
    drive(1'b1, 96'h66, 1'b1, 1'b0);
    tick();
    drive(1'b1, 96'h67, 1'b1, 1'b1);
    #1;
    n_checks++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 96'h66)
      $display("FAIL flush_drain_out: got v=%b d=%h expected v=1 d=66", bus.o_valid, bus.o_data);
    else n_pass++;
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (bus.o_valid !== 1'b0) $display("FAIL flush_drain_empty: got %b expected 0", bus.o_valid);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [PW-1:0] front;
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 9) < 7, {$urandom, $urandom, $urandom},
            $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
      bus.i_ctrl = CTRL_W'($urandom);
      #1;
      front = (mq.size() > 0) ? mq[0] : '0;
      n_checks++;
      if (bus.o_valid !== (mq.size() > 0)) $display("FAIL rnd_valid[%0d]: got %b expected %b", n, bus.o_valid, mq.size() > 0);
      else n_pass++;
      n_checks++;
      if (bus.o_ready !== m_ready()) $display("FAIL rnd_ready[%0d]: got %b expected %b", n, bus.o_ready, m_ready());
      else n_pass++;
      if (mq.size() > 0 || m_zero) begin
        n_checks++;
        if (bus.o_data !== front[PW-1:CTRL_W] || bus.o_ctrl !== front[CTRL_W-1:0])
          $display("FAIL rnd_payload[%0d]: got %h/%h expected %h/%h", n, bus.o_data, bus.o_ctrl,
                   front[PW-1:CTRL_W], front[CTRL_W-1:0]);
        else n_pass++;
      end
      n_checks++;
      if (bus.o_stall_cnt !== CNT_W'(m_cnt)) $display("FAIL rnd_cnt[%0d]: got %0d expected %0d", n, bus.o_stall_cnt, m_cnt);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_stall_sat();
    drive(1'b1, 96'h77, 1'b0, 1'b0);
    tick();
    bus.i_valid = 1'b0;
    repeat (10) tick();
    #1;
    n_checks++;
    if (bus.o_stall_cnt !== CNT_W'(m_cnt)) $display("FAIL stall_count: got %0d expected %0d", bus.o_stall_cnt, m_cnt);
    else n_pass++;
    repeat (70000) tick();
    #1;
    n_checks++;
    if (bus.o_stall_cnt !== 16'hFFFF) $display("FAIL stall_sat: got %h expected ffff", bus.o_stall_cnt);
    else n_pass++;
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    #1;
    n_checks++;
    if (bus.o_stall_cnt !== 16'hFFFF || bus.o_valid !== 1'b0)
      $display("FAIL stall_after_flush: got cnt=%h v=%b expected ffff/0", bus.o_stall_cnt, bus.o_valid);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    drive(1'b1, 96'h88, 1'b0, 1'b0);
    tick();
    #2;
    i_rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.o_valid !== 1'b0 || bus.o_data !== '0 || bus.o_stall_cnt !== '0)
      $display("FAIL async_reset: got v=%b d=%h cnt=%0d expected 0/0/0", bus.o_valid, bus.o_data, bus.o_stall_cnt);
    else n_pass++;
    tick();
    i_rst_n = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
  endtask

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge i_clk);
    test_reset();
    test_stream();
`ifdef PIPE_STAGE_SKID_EN
    test_skid();
`else
    test_single_replace();
`endif
    test_flush();
    test_random();
    test_stall_sat();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
